// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter for one shared register.
// Requesters present data plus a bit mask. Each grant commits one masked
// write, so the shared register has a single registered driver.
// An arbitration cycle (IDLE) is always followed by one WRITE cycle.
module shared_reg_arbiter #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic [NREQ*WIDTH-1:0] wmask,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  contend,
    output logic [7:0]            wr_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              contend_q, contend_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [IW:0]       pick_s;
    logic [WIDTH-1:0]  sel_data_s;
    logic [WIDTH-1:0]  sel_mask_s;

    // Round-robin search from the pointer; MSB of the result flags "found".
    function automatic logic [IW:0] pick_winner(input logic [NREQ-1:0] r,
                                                input logic [IW-1:0]   p);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!res[IW] && r[idx]) begin
                res = {1'b1, IW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Number of active requests, used for the contention flag.
    function automatic int count_ones(input logic [NREQ-1:0] r);
        int n;
        n = 0;
        for (int k = 0; k < NREQ; k++) begin
            n = n + int'(r[k]);
        end
        return n;
    endfunction

    assign pick_s = pick_winner(req, ptr_q);

    // Mux out the winning requester's data and mask slices.
    always_comb begin
        sel_data_s = '0;
        sel_mask_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_s[IW-1:0] == IW'(i)) begin
                sel_data_s = wdata[i*WIDTH +: WIDTH];
                sel_mask_s = wmask[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
                sel_mask_s = sel_mask_s;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, commit the latched write in WRITE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        data_d    = data_q;
        mask_d    = mask_q;
        shreg_d   = shreg_q;
        contend_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_s[IW]) begin
                    win_d     = pick_s[IW-1:0];
                    data_d    = sel_data_s;
                    mask_d    = sel_mask_s;
                    contend_d = (count_ones(req) > 1) ? 1'b1 : 1'b0;
                    state_d   = WRITE;
                end else begin
                    contend_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                shreg_d   = (shreg_q & ~mask_q) | (data_q & mask_q);
                ptr_d     = (win_q == IW'(NREQ - 1)) ? '0 : (win_q + IW'(1));
                cnt_d     = (cnt_q == 8'hFF) ? 8'hFF : (cnt_q + 8'd1);
                contend_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d   = IDLE;
                contend_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            shreg_q   <= '0;
            contend_q <= 1'b0;
            cnt_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            shreg_q   <= shreg_d;
            contend_q <= contend_d;
            cnt_q     <= cnt_d;
        end
    end

    // Grant is a pure decode of registered state: one-hot winner during WRITE.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_q == WRITE) && (win_q == IW'(i))) begin
                gnt[i] = 1'b1;
            end else begin
                gnt[i] = 1'b0;
            end
        end
    end

    assign q        = shreg_q;
    assign contend  = contend_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Testbench for shared_reg_arbiter: directed scenarios plus randomized
// handshaking requesters, checked against a transaction-level model.
module tb_shared_reg_arbiter;

    localparam int NREQ  = 3;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ*WIDTH-1:0] wmask;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  contend;
    logic [7:0]            wr_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register value, rotating pointer, write count and
    // the write captured at the last arbitration (pending until committed).
    logic [WIDTH-1:0] m_q;
    int               m_ptr;
    int               m_cnt;
    int               m_w;
    bit               m_pending;
    bit               m_contend;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;

    shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
        .wmask    (wmask),
        .gnt      (gnt),
        .q        (q),
        .contend  (contend),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    function automatic int first_active(input logic [NREQ-1:0] r, input int from);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_gnt();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_pending) g[m_w] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_q = '0; m_ptr = 0; m_cnt = 0; m_w = 0;
        m_pending = 1'b0; m_contend = 1'b0; m_data = '0; m_mask = '0;
    endtask

    // One clock edge as seen by the model, using the inputs present at the edge.
    task automatic model_edge();
        if (m_pending) begin
            m_q       = (m_q & ~m_mask) | (m_data & m_mask);
            m_ptr     = (m_w + 1) % NREQ;
            m_cnt     = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_pending = 1'b0;
            m_contend = 1'b0;
        end else if (req != '0) begin
            m_w       = first_active(req, m_ptr);
            m_data    = wdata[m_w*WIDTH +: WIDTH];
            m_mask    = wmask[m_w*WIDTH +: WIDTH];
            m_pending = 1'b1;
            m_contend = ($countones(req) > 1);
        end else begin
            m_contend = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        wdata[i*WIDTH +: WIDTH] = d;
        wmask[i*WIDTH +: WIDTH] = m;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; wdata = '0; wmask = '0;
        #12;
        model_reset();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        n_cmp++; if (q !== 4'h0) begin n_err++; $display("FAIL reset_q got=%h exp=0", q); end
        n_cmp++; if (contend !== 1'b0) begin n_err++; $display("FAIL reset_contend got=%b exp=0", contend); end
        n_cmp++; if (wr_count !== 8'd0) begin n_err++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        set_req(0, 4'hA, 4'hF);
        req = 3'b001;
        tick();
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL single_gnt got=%b exp=001", gnt); end
        n_cmp++; if (q !== 4'h0) begin n_err++; $display("FAIL single_q_early got=%h exp=0", q); end
        n_cmp++; if (contend !== 1'b0) begin n_err++; $display("FAIL single_contend got=%b exp=0", contend); end
        tick();
        req = 3'b000;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL single_gnt_end got=%b exp=000", gnt); end
        n_cmp++; if (q !== 4'hA) begin n_err++; $display("FAIL single_q got=%h exp=a", q); end
        n_cmp++; if (wr_count !== 8'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", wr_count); end
        tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL single_gnt_once got=%b exp=000", gnt); end
    endtask

    task automatic test_partial_mask();
        set_req(1, 4'h5, 4'h3);
        req = 3'b010;
        tick();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL partial_gnt got=%b exp=010", gnt); end
        tick();
        req = 3'b000;
        n_cmp++; if (q !== 4'h9) begin n_err++; $display("FAIL partial_q got=%h exp=9", q); end
        n_cmp++; if (q !== m_q) begin n_err++; $display("FAIL partial_q_model got=%h exp=%h", q, m_q); end
        tick();
    endtask

    task automatic test_round_robin();
        int              order[$];
        int              exp_order[4];
        logic [NREQ-1:0] pre;
        exp_order = '{0, 1, 2, 0};
        apply_reset();
        set_req(0, 4'h1, 4'hF); set_req(1, 4'h2, 4'hF); set_req(2, 4'h3, 4'hF);
        req = 3'b111;
        for (int c = 0; c < 8; c++) begin
            pre = exp_gnt();
            tick();
            n_cmp++; if (gnt !== exp_gnt()) begin n_err++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt()); end
            n_cmp++; if (contend !== m_contend) begin n_err++; $display("FAIL rr_contend cyc=%0d got=%b exp=%b", c, contend, m_contend); end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) order.push_back(i);
                req[i] = pre[i] ? 1'b0 : 1'b1;
            end
        end
        req = '0;
        n_cmp++; if (order.size() < 4) begin n_err++; $display("FAIL rr_count got=%0d exp>=4", order.size()); end
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            n_cmp++; if (order[k] != exp_order[k]) begin n_err++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, order[k], exp_order[k]); end
        end
        tick(); tick();
    endtask

    task automatic test_zero_mask();
        int cnt_before;
        set_req(0, 4'h6, 4'hF);
        req = 3'b001;
        tick(); tick();
        req = 3'b000;
        tick();
        n_cmp++; if (q !== 4'h6) begin n_err++; $display("FAIL zmask_setup_q got=%h exp=6", q); end
        cnt_before = m_cnt;
        set_req(0, 4'hF, 4'h0);
        req = 3'b001;
        tick();
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL zmask_gnt got=%b exp=001", gnt); end
        tick();
        req = 3'b000;
        n_cmp++; if (q !== 4'h6) begin n_err++; $display("FAIL zmask_q got=%h exp=6", q); end
        n_cmp++; if (int'(wr_count) != cnt_before + 1) begin n_err++; $display("FAIL zmask_count got=%0d exp=%0d", wr_count, cnt_before + 1); end
        tick();
    endtask

    task automatic test_reset_in_write();
        set_req(1, 4'hC, 4'hF);
        req = 3'b010;
        tick(); tick();
        req = 3'b000;
        tick();
        n_cmp++; if (q !== 4'hC) begin n_err++; $display("FAIL rstw_setup_q got=%h exp=c", q); end
        set_req(1, 4'h3, 4'hF);
        req = 3'b010;
        tick();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rstw_gnt got=%b exp=010", gnt); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rstw_gnt_cleared got=%b exp=000", gnt); end
        n_cmp++; if (q !== 4'h0) begin n_err++; $display("FAIL rstw_q got=%h exp=0", q); end
        set_req(1, 4'h7, 4'hF);
        set_req(2, 4'h5, 4'hF);
        req = 3'b110;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rstw_first_gnt got=%b exp=010", gnt); end
        n_cmp++; if (q !== 4'h0) begin n_err++; $display("FAIL rstw_q_hold got=%h exp=0", q); end
        tick();
        req = 3'b000;
        n_cmp++; if (q !== 4'h7) begin n_err++; $display("FAIL rstw_q_after got=%h exp=7", q); end
        tick(); tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pre;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            pre = exp_gnt();
            tick();
            n_cmp++; if (gnt !== exp_gnt()) begin n_err++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt()); end
            n_cmp++; if ($countones(gnt) > 1) begin n_err++; $display("FAIL rand_onehot cyc=%0d got=%b exp=onehot", c, gnt); end
            n_cmp++; if (q !== m_q) begin n_err++; $display("FAIL rand_q cyc=%0d got=%h exp=%h", c, q, m_q); end
            n_cmp++; if (contend !== m_contend) begin n_err++; $display("FAIL rand_contend cyc=%0d got=%b exp=%b", c, contend, m_contend); end
            n_cmp++; if (int'(wr_count) != m_cnt) begin n_err++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, wr_count, m_cnt); end
            for (int i = 0; i < NREQ; i++) begin
                if (pre[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
                    req[i] = 1'b1;
                    set_req(i, WIDTH'($urandom), WIDTH'($urandom));
                end
            end
            // The winner's inputs may change after capture without effect.
            if (m_pending && ($urandom_range(0, 1) == 1)) begin
                set_req(m_w, WIDTH'($urandom), WIDTH'($urandom));
            end
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] last;
        apply_reset();
        last = WIDTH'($urandom);
        set_req(0, last, 4'hF);
        req = 3'b001;
        for (int c = 0; c < 520; c++) begin
            tick();
            n_cmp++; if (int'(wr_count) != m_cnt) begin n_err++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", c, wr_count, m_cnt); end
            if (exp_gnt() != '0) begin
                last = wdata[WIDTH-1:0];
                set_req(0, WIDTH'($urandom), 4'hF);
            end
        end
        req = '0;
        tick();
        n_cmp++; if (wr_count !== 8'd255) begin n_err++; $display("FAIL b2b_saturate got=%0d exp=255", wr_count); end
        n_cmp++; if (q !== last) begin n_err++; $display("FAIL b2b_last_q got=%h exp=%h", q, last); end
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL b2b_idle_gnt got=%b exp=000", gnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_partial_mask();
        test_round_robin();
        test_zero_mask();
        test_reset_in_write();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin write arbiter for one WIDTH-bit shared register that several producers would otherwise drive directly.
- Each requester presents data plus a bit mask; one masked write is committed per grant.
- This gives the shared register a single registered driver.
- Sits between the combinational producer logic and the register consumed by downstream logic.

Parameters:
- NREQ, 3, number of requesters (2..8).
- WIDTH, 4, shared register width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester write request, level.
- wdata  input  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH].
- wmask  input  NREQ*WIDTH  write-enable mask per bit, same packing as wdata.
- gnt  output  NREQ  one-hot grant; high for the write cycle.
- q  output  WIDTH  shared register value.
- contend  output  1  registered pulse: more than one req was high at an arbitration edge.
- wr_count  output  8  saturating count of committed writes.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE, q=0, ptr=0, contend=0, wr_count=0.
  - Latched winner/data/mask are cleared.
  - gnt=0 immediately, because it is decoded from state.
- FSM, two states:
  - IDLE: at a rising edge with any req high:
    - Latch winner index w, wdata slice w, and wmask slice w.
    - Go to WRITE.
    - contend<=1 if popcount(req)>1, else contend<=0.
  - IDLE with no req: stay in IDLE; contend<=0.
  - WRITE: always lasts exactly one cycle.
    - At the next edge: q <= (q & ~mask_l) | (data_l & mask_l).
    - ptr <= (w+1) mod NREQ.
    - wr_count <= wr_count+1, saturating at 255.
    - state<=IDLE; contend<=0.
- gnt = onehot(w) while state==WRITE, else 0. It is a pure decode of registers, with no combinational path from req.
- Handshake:
  - A requester holds req, wdata and wmask until it samples gnt[i]=1 at a rising edge, then deasserts req in the following cycle.
  - Data is captured at the arbitration edge; changes after that edge are ignored for that write.
- Latency:
  - req high before edge E0 → gnt high between E0 and E1 → new q visible after E1.
  - Peak throughput is one write per two cycles.
- Round-robin rule:
  - Winner is the first requester with req high, searching ptr, ptr+1, … with wrap at NREQ.
  - Reset priority order is 0,1,2.
- Boundary conditions:
  - mask=0: the grant is still issued and wr_count still increments; q is unchanged.
  - All-ones mask: full overwrite.
  - A req dropped during WRITE does not cancel the latched write.
  - wr_count holds at 255.
  - Reset asserted while in WRITE: the pending write is discarded and q=0.
  - A req held past its grant is re-arbitrated as a new request. It gets no priority, because ptr has already advanced past it.
- Invariants: gnt is zero or one-hot; q changes only on the edge that ends WRITE.

Test Plan:
- Reset, then req=3'b001, wdata0=4'hA, wmask0=4'hF; drop req after the grant.
  - gnt=001 for exactly one cycle; q=4'hA after it; wr_count=1; contend=0.
- q=4'hA, then req1 with wdata=4'h5, wmask=4'h3.
  - q=4'h9 (upper bits kept, lower two bits written).
- All three req held continuously with wmask=F and wdata 1/2/3; each requester drops req for one cycle after its grant.
  - Grant order is 0,1,2,0; contend pulses high at each arbitration edge where ≥2 req are high.
- req0 with wmask=0, wdata=F from q=4'h6.
  - gnt0 issued; q stays 4'h6; wr_count increments.
- rst_n pulled low during WRITE (gnt=010, q=4'hC).
  - gnt=0 immediately; q=0; after release, the first grant goes to the lowest-index active requester.
- 260 back-to-back single-requester writes.
  - wr_count saturates at 255; q tracks the last written value.
